// File: rtl/lamp_ctrl_pkg.sv
// Shared definitions for the lamp controller: FSM state encoding and width helpers.
package lamp_ctrl_pkg;

    typedef enum logic [1:0] {
        S_OFF       = 2'b00,
        S_GUARD_ON  = 2'b01,
        S_ON        = 2'b10,
        S_GUARD_OFF = 2'b11
    } lamp_state_e;

    // Bits needed to hold a counter value in 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

    // Bits needed to index n items (never less than one).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button conditioning: 2-flop synchroniser, stability counter and rising-edge pulse.
module btn_debounce
    import lamp_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYC);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differ, flip;

    assign differ = sync2_q ^ level_q;
    assign flip   = differ && (cnt_q == CW'(DEBOUNCE_CYC - 1));

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (flip) begin
            level_d = ~level_q;
        end else if (differ) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_out = level_q;
    // Asserted in the cycle the level flips so the request lands on the same edge.
    assign rise_pulse = flip & ~level_q;

endmodule

// File: rtl/lamp_ctrl_arb.sv
// Shared-lamp controller: debounced buttons, round-robin grant, guard window.
// Optional auto-off timer enabled by defining LAMP_CTRL_AUTO_OFF_EN.
module lamp_ctrl_arb
    import lamp_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BTN      = 4,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned GUARD_CYC    = 64,
    parameter int unsigned TIMEOUT_CYC  = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_BTN-1:0]            btn_in,
    output logic                          lamp_on,
    output logic                          grant_valid,
    output logic [idx_width(NUM_BTN)-1:0] grant_id,
    output logic                          timeout_pulse
);

    localparam int unsigned IDW = idx_width(NUM_BTN);
    localparam int unsigned GW  = cnt_width(GUARD_CYC);

    logic [NUM_BTN-1:0] btn_rise;
    lamp_state_e        state_q, state_d;
    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [GW-1:0]      guard_q, guard_d;
    logic               lamp_q, lamp_d;
    logic               grant_valid_q, grant_valid_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic               win_found;
    logic [IDW-1:0]     win_idx;
    int                 cand;
    logic               grant;
    logic               tmr_hit;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_debounce (
            .clk       (clk),
            .reset     (reset),
            .raw_in    (btn_in[g]),
            .level_out (),
            .rise_pulse(btn_rise[g])
        );
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= int'(NUM_BTN); k++) begin
            cand = (int'(ptr_q) + k) % int'(NUM_BTN);
            if (!win_found && pending_q[cand]) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand);
            end
        end
    end

    assign grant = win_found && ((state_q == S_OFF) || (state_q == S_ON));

`ifdef LAMP_CTRL_AUTO_OFF_EN
    localparam int unsigned TW = cnt_width(TIMEOUT_CYC);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          timeout_q;

    assign tmr_hit = (state_q == S_ON) && (tmr_q == TW'(TIMEOUT_CYC - 1));
    // Runs only while idling in S_ON, so it is zero on every entry to S_ON.
    assign tmr_d = ((state_q == S_ON) && !tmr_hit && !grant) ? tmr_q + TW'(1) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            timeout_q <= tmr_hit;
        end
    end

    assign timeout_pulse = timeout_q;
`else
    assign tmr_hit       = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q | btn_rise;
        ptr_d         = ptr_q;
        guard_d       = guard_q;
        lamp_d        = lamp_q;
        grant_valid_d = 1'b0;
        grant_id_d    = grant_id_q;

        if (grant) begin
            pending_d     = '0;
            ptr_d         = win_idx;
            grant_valid_d = 1'b1;
            grant_id_d    = win_idx;
            guard_d       = '0;
        end

        unique case (state_q)
            S_OFF: begin
                if (grant) begin
                    state_d = S_GUARD_ON;
                    lamp_d  = 1'b1;
                end
            end
            S_ON: begin
                // A grant coinciding with timeout wins the transition.
                if (grant) begin
                    state_d = S_GUARD_OFF;
                    lamp_d  = 1'b0;
                end else if (tmr_hit) begin
                    state_d = S_OFF;
                    lamp_d  = 1'b0;
                end
            end
            S_GUARD_ON, S_GUARD_OFF: begin
                pending_d = '0;
                if (guard_q == GW'(GUARD_CYC - 1)) begin
                    guard_d = '0;
                    state_d = (state_q == S_GUARD_ON) ? S_ON : S_OFF;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_OFF;
            pending_q     <= '0;
            ptr_q         <= IDW'(NUM_BTN - 1);
            guard_q       <= '0;
            lamp_q        <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            ptr_q         <= ptr_d;
            guard_q       <= guard_d;
            lamp_q        <= lamp_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
        end
    end

    assign lamp_on     = lamp_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_lamp_ctrl_arb.sv
// Directed self-checking bench for lamp_ctrl_arb (NUM_BTN=4, DEBOUNCE=4, GUARD=8, TIMEOUT=32).
module tb_lamp_ctrl_arb;

    logic       clk;
    logic       reset;
    logic [3:0] btn_in;
    logic       lamp_on;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       timeout_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int gv_cnt   = 0;
    int to_cnt   = 0;
    int gv_base;
    int to_base;

    lamp_ctrl_arb #(
        .NUM_BTN     (4),
        .DEBOUNCE_CYC(4),
        .GUARD_CYC   (8),
        .TIMEOUT_CYC (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .lamp_on      (lamp_on),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .timeout_pulse(timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (grant_valid) gv_cnt++;
            if (timeout_pulse) to_cnt++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    initial begin
        btn_in = '0;
        reset  = 1'b1;
        #3;
        check("rst_lamp", int'(lamp_on), 0);
        check("rst_grant_valid", int'(grant_valid), 0);
        check("rst_grant_id", int'(grant_id), 0);
        check("rst_timeout", int'(timeout_pulse), 0);
        step(2);
        reset = 1'b0;
        step(2);

        // Glitch of 3 cycles must not reach pending.
        gv_base = gv_cnt;
        btn_in[1] = 1'b1;
        step(3);
        btn_in[1] = 1'b0;
        step(20);
        check("glitch_no_grant", gv_cnt - gv_base, 0);
        check("glitch_lamp", int'(lamp_on), 0);

        // Single press: grant and lamp 7 cycles after the rise.
        gv_base = gv_cnt;
        btn_in[2] = 1'b1;
        step(6);
        check("single_early_lamp", int'(lamp_on), 0);
        check("single_early_gv", int'(grant_valid), 0);
        step(1);
        check("single_gv", int'(grant_valid), 1);
        check("single_id", int'(grant_id), 2);
        check("single_lamp", int'(lamp_on), 1);
        step(1);
        check("single_gv_pulse", int'(grant_valid), 0);
        step(2);
        btn_in[2] = 1'b0;
        step(20);
        check("single_one_grant", gv_cnt - gv_base, 1);
        check("single_lamp_held", int'(lamp_on), 1);

        // Simultaneous 0 and 3, then a press during guard that must be dropped.
        reset_dut();
        gv_base = gv_cnt;
        btn_in = 4'b1001;
        step(7);
        check("simul_gv", int'(grant_valid), 1);
        check("simul_id", int'(grant_id), 0);
        check("simul_lamp", int'(lamp_on), 1);
        btn_in = 4'b1011;
        step(3);
        btn_in = 4'b0010;
        step(3);
        btn_in = 4'b0000;
        step(7);
        check("guard_press_lamp", int'(lamp_on), 1);
        check("guard_press_grants", gv_cnt - gv_base, 1);

        // Round robin: 0 and 1 pending with pointer at 0 -> button 1.
        btn_in = 4'b0011;
        step(7);
        check("rr_gv", int'(grant_valid), 1);
        check("rr_id", int'(grant_id), 1);
        check("rr_lamp", int'(lamp_on), 0);
        btn_in = 4'b0000;
        step(12);
        check("rr_grants", gv_cnt - gv_base, 2);

        // Auto-off window: 8 guard cycles then 32 cycles in S_ON.
        reset_dut();
        to_base = to_cnt;
        btn_in[2] = 1'b1;
        step(7);
        check("ao_on", int'(lamp_on), 1);
        btn_in = 4'b0000;
        step(39);
        check("ao_before_lamp", int'(lamp_on), 1);
        check("ao_before_to", int'(timeout_pulse), 0);
`ifdef LAMP_CTRL_AUTO_OFF_EN
        step(1);
        check("ao_fire_lamp", int'(lamp_on), 0);
        check("ao_fire_to", int'(timeout_pulse), 1);
        step(1);
        check("ao_to_pulse", int'(timeout_pulse), 0);
        step(20);
        check("ao_to_count", to_cnt - to_base, 1);
        check("ao_lamp_off", int'(lamp_on), 0);
`else
        step(40);
        check("noao_lamp", int'(lamp_on), 1);
        check("noao_to_count", to_cnt - to_base, 0);
`endif

        // Asynchronous reset inside the guard window, then priority restarts at 0.
        reset_dut();
        btn_in[0] = 1'b1;
        step(7);
        check("rg_id", int'(grant_id), 0);
        check("rg_lamp", int'(lamp_on), 1);
        btn_in = 4'b0000;
        step(3);
        reset = 1'b1;
        #1;
        check("rg_async_lamp", int'(lamp_on), 0);
        check("rg_async_gv", int'(grant_valid), 0);
        step(2);
        reset = 1'b0;
        step(1);
        btn_in = 4'b0011;
        step(7);
        check("rg_after_gv", int'(grant_valid), 1);
        check("rg_after_id", int'(grant_id), 0);
        check("rg_after_lamp", int'(lamp_on), 1);
        btn_in = 4'b0000;
        step(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
